// File: rtl/scl180_spare_logic_bank_if.sv
// Configuration-chain and slot signal bundle for the SCL180 spare logic bank.
// The master side drives config and slot inputs; the slave side is the bank itself.
interface scl180_spare_logic_bank_if #(
  parameter int unsigned NUM_SLOTS = 4
);
  logic                 cfg_shift_en;
  logic                 cfg_sdi;
  logic                 cfg_commit;
  logic                 cfg_sdo;
  logic                 cfg_err;
  logic [NUM_SLOTS-1:0] slot_a;
  logic [NUM_SLOTS-1:0] slot_b;
  logic [NUM_SLOTS-1:0] slot_y;

  modport master (
    output cfg_shift_en, cfg_sdi, cfg_commit, slot_a, slot_b,
    input  cfg_sdo, cfg_err, slot_y
  );

  modport slave (
    input  cfg_shift_en, cfg_sdi, cfg_commit, slot_a, slot_b,
    output cfg_sdo, cfg_err, slot_y
  );
endinterface

// File: rtl/scl180_spare_logic_bank.sv
// Configurable spare-logic bank: each slot is tie/gate/flop selected by a 3-bit mode.
// Modes are shifted into a shadow chain and committed atomically when the bit count is exact.
module scl180_spare_logic_bank #(
  parameter  int unsigned NUM_SLOTS = 4,
  localparam int unsigned CFG_W     = 3 * NUM_SLOTS
) (
`ifdef USE_POWER_PINS
  inout  wire  VPWR,
  inout  wire  VGND,
`endif
  input  logic clock,
  input  logic resetb,
  scl180_spare_logic_bank_if.slave bus,
  output logic LO,
  output logic HI
);

  typedef enum logic [2:0] {
    M_TIE_LO = 3'd0,
    M_TIE_HI = 3'd1,
    M_INV    = 3'd2,
    M_NAND   = 3'd3,
    M_NOR    = 3'd4,
    M_BUF    = 3'd5,
    M_DFF    = 3'd6,
    M_TOGGLE = 3'd7
  } slot_mode_e;

  localparam int unsigned      CNT_W    = $clog2(CFG_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
  localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(CFG_W + 1);

  logic [CFG_W-1:0]     shadow;
  logic [CFG_W-1:0]     active;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 cfg_err;
  logic                 commit_ok;
  logic [NUM_SLOTS-1:0] q;
  logic [NUM_SLOTS-1:0] q_next;
  logic [NUM_SLOTS-1:0] y;

  assign commit_ok = bus.cfg_commit && (bit_cnt == CNT_FULL);

  // Commit takes priority over shifting and over the per-slot flop update.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      shadow  <= '0;
      active  <= '0;
      bit_cnt <= '0;
      cfg_err <= 1'b0;
      q       <= '0;
    end else if (bus.cfg_commit) begin
      bit_cnt <= '0;
      if (commit_ok) begin
        active  <= shadow;
        cfg_err <= 1'b0;
        q       <= '0;
      end else begin
        cfg_err <= 1'b1;
      end
    end else begin
      q <= q_next;
      if (bus.cfg_shift_en) begin
        shadow <= {bus.cfg_sdi, shadow[CFG_W-1:1]};
        if (bit_cnt != CNT_OVF) begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    q_next = q;
    y      = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      unique case (slot_mode_e'(active[3*i +: 3]))
        M_TIE_LO: y[i] = 1'b0;
        M_TIE_HI: y[i] = 1'b1;
        M_INV:    y[i] = ~bus.slot_a[i];
        M_NAND:   y[i] = ~(bus.slot_a[i] & bus.slot_b[i]);
        M_NOR:    y[i] = ~(bus.slot_a[i] | bus.slot_b[i]);
        M_BUF:    y[i] = bus.slot_a[i];
        M_DFF: begin
          y[i]      = q[i];
          q_next[i] = bus.slot_a[i];
        end
        M_TOGGLE: begin
          y[i]      = q[i];
          q_next[i] = q[i] ^ bus.slot_a[i];
        end
        default:  y[i] = 1'b0;
      endcase
    end
  end

  assign bus.slot_y  = y;
  assign bus.cfg_sdo = shadow[0];
  assign bus.cfg_err = cfg_err;
  assign LO          = 1'b0;
  assign HI          = 1'b1;

endmodule

// File: tb/tb_scl180_spare_logic_bank.sv
// Randomised self-checking bench for scl180_spare_logic_bank against an integer-level
// model of the shadow chain, commit rule and slot truth table.
module tb_scl180_spare_logic_bank;
  localparam int NS = 4;
  localparam int CW = 3 * NS;

  logic clock;
  logic resetb;
  logic LO, HI;

  scl180_spare_logic_bank_if #(.NUM_SLOTS(NS)) bus ();

  scl180_spare_logic_bank #(.NUM_SLOTS(NS)) dut (
    .clock  (clock),
    .resetb (resetb),
    .bus    (bus),
    .LO     (LO),
    .HI     (HI)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model state: plain integers and bit arrays
  int unsigned m_shadow;
  int unsigned m_active;
  int          m_cnt;
  bit          m_err;
  bit          m_q[NS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_shadow = 0;
    m_active = 0;
    m_cnt    = 0;
    m_err    = 1'b0;
    for (int i = 0; i < NS; i++) m_q[i] = 1'b0;
  endfunction

  function automatic int mode_of(int i);
    return int'((m_active >> (3 * i)) % 8);
  endfunction

  function automatic logic [NS-1:0] model_y(input logic [NS-1:0] a, input logic [NS-1:0] b);
    logic [NS-1:0] r;
    r = '0;
    for (int i = 0; i < NS; i++) begin
      case (mode_of(i))
        0: r[i] = 1'b0;
        1: r[i] = 1'b1;
        2: r[i] = !a[i];
        3: r[i] = !(a[i] && b[i]);
        4: r[i] = !(a[i] || b[i]);
        5: r[i] = a[i];
        default: r[i] = m_q[i];
      endcase
    end
    return r;
  endfunction

  function automatic void model_edge(input bit se, input bit sdi, input bit cm,
                                     input logic [NS-1:0] a);
    if (cm) begin
      if (m_cnt == CW) begin
        m_active = m_shadow;
        m_err    = 1'b0;
        for (int i = 0; i < NS; i++) m_q[i] = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_cnt = 0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (mode_of(i) == 6) m_q[i] = a[i];
        else if (mode_of(i) == 7) m_q[i] = m_q[i] ^ a[i];
      end
      if (se) begin
        m_shadow = (m_shadow / 2) + (int'(sdi) << (CW - 1));
        m_cnt    = (m_cnt + 1 > CW + 1) ? CW + 1 : m_cnt + 1;
      end
    end
  endfunction

  // Entered and left at a falling edge; outputs checked before the rising edge.
  task automatic step(input bit se, input bit sdi, input bit cm,
                      input logic [NS-1:0] a, input logic [NS-1:0] b);
    bus.cfg_shift_en = se;
    bus.cfg_sdi      = sdi;
    bus.cfg_commit   = cm;
    bus.slot_a       = a;
    bus.slot_b       = b;
    #1;
    check("slot_y",  32'(bus.slot_y),  32'(model_y(a, b)));
    check("cfg_sdo", 32'(bus.cfg_sdo), 32'(m_shadow % 2));
    check("cfg_err", 32'(bus.cfg_err), 32'(m_err));
    @(posedge clock);
    model_edge(se, sdi, cm, a);
    @(negedge clock);
  endtask

  task automatic shift_word(input int unsigned word, input int n,
                            input logic [NS-1:0] a, input logic [NS-1:0] b);
    for (int i = 0; i < n; i++) step(1'b1, bit'((word >> i) % 2), 1'b0, a, b);
  endtask

  task automatic commit(input logic [NS-1:0] a, input logic [NS-1:0] b);
    step(1'b0, 1'b0, 1'b1, a, b);
  endtask

  task automatic async_reset();
    #2 resetb = 1'b0;
    #1;
    check("rst_slot_y",  32'(bus.slot_y),  32'h0);
    check("rst_cfg_err", 32'(bus.cfg_err), 32'h0);
    check("rst_cfg_sdo", 32'(bus.cfg_sdo), 32'h0);
    check("rst_LO",      32'(LO),          32'h0);
    check("rst_HI",      32'(HI),          32'h1);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    resetb = 1'b1;
  endtask

  initial begin
    logic [CW-1:0] rd;
    int unsigned w;
    int n;
    resetb           = 1'b0;
    bus.cfg_shift_en = 1'b0;
    bus.cfg_sdi      = 1'b0;
    bus.cfg_commit   = 1'b0;
    bus.slot_a       = '0;
    bus.slot_b       = '0;
    model_reset();
    repeat (2) @(negedge clock);
    resetb = 1'b1;

    // Reset: first build non-reset state (all tie-hi, sticky error)
    shift_word(32'h249, CW, 4'h0, 4'h0);
    commit(4'h0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h5, 4'hA);
    check("tiehi_all", 32'(bus.slot_y), 32'hF);
    commit(4'h0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    check("err_set", 32'(bus.cfg_err), 32'h1);
    async_reset();

    // Mixed gates plus toggle slot
    shift_word(32'hF1A, CW, 4'h0, 4'h0);
    commit(4'b0011, 4'b0110);
    step(1'b0, 1'b0, 1'b0, 4'b0011, 4'b0110);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 4'b1000, 4'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 4'($urandom), 4'($urandom));

    // Short and long loads are rejected; an exact load recovers
    shift_word(32'h249, CW - 1, 4'h3, 4'h3);
    commit(4'h3, 4'h3);
    step(1'b0, 1'b0, 1'b0, 4'h3, 4'h3);
    shift_word(32'h249, CW + 1, 4'h6, 4'h1);
    commit(4'h6, 4'h1);
    step(1'b0, 1'b0, 1'b0, 4'h6, 4'h1);
    shift_word(32'hF1A, CW, 4'h0, 4'h0);
    commit(4'h0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h9, 4'h9);

    // Commit beats a coincident shift; shadow reads back intact
    shift_word(32'hF1A, CW, 4'h0, 4'h0);
    step(1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
    rd = '0;
    for (int i = 0; i < CW; i++) begin
      rd[i] = bus.cfg_sdo;
      step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    end
    check("readback", 32'(rd), 32'hF1A);
    commit(4'h0, 4'h0);

    // DFF slot latency and commit-time clear
    shift_word(32'h006, CW, 4'h0, 4'h0);
    commit(4'h0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h1, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h1, 4'h0);
    check("dff_rise", 32'(bus.slot_y[0]), 32'h1);
    shift_word(32'h006, CW, 4'h1, 4'h0);
    commit(4'h1, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h1, 4'h0);

    // Reset mid-shift discards partial content
    shift_word(32'hF1A, 6, 4'h0, 4'h0);
    async_reset();
    commit(4'hF, 4'hF);
    step(1'b0, 1'b0, 1'b0, 4'hF, 4'h0);
    check("post_rst_err", 32'(bus.cfg_err), 32'h1);

    // Randomised loads of random words with random bit counts
    for (int t = 0; t < 60; t++) begin
      w = $urandom % (1 << CW);
      n = ($urandom % 4 == 0) ? int'($urandom_range(0, CW + 3)) : CW;
      for (int i = 0; i < n; i++)
        step(1'b1, bit'((w >> i) % 2), 1'b0, 4'($urandom), 4'($urandom));
      step($urandom % 2 == 1, $urandom % 2 == 1, 1'b1, 4'($urandom), 4'($urandom));
      for (int i = 0; i < 6; i++)
        step($urandom % 8 == 0, $urandom % 2 == 1, $urandom % 16 == 0,
             4'($urandom), 4'($urandom));
      if (t % 20 == 19) async_reset();
    end

    check("LO_static", 32'(LO), 32'h0);
    check("HI_static", 32'(HI), 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
